// File: rtl/seq_gen_1010_if.sv
// Handshake and serial-stream bundle between a burst controller and seq_gen_1010.
// The controller holds the master modport; the generator holds the slave modport.
interface seq_gen_1010_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic             abort;
    logic             use_def;
    logic [PAT_W-1:0] pat_in;
    logic [CNT_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             x_out;
    logic             x_vld;
    logic             sof;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, use_def, pat_in, rep_cnt, gap_cnt,
        input  x_out, x_vld, sof, busy, done
    );

    modport slave (
        input  start, abort, use_def, pat_in, rep_cnt, gap_cnt,
        output x_out, x_vld, sof, busy, done
    );
endinterface

// File: rtl/seq_gen_1010.sv
// Serial pattern burst generator: sends a PAT_W-bit pattern MSB first, repeated
// with an optional idle gap between repetitions.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// SEND  | driving pattern bits with x_vld
// GAP   | idle bits between repetitions
// DONE  | one-cycle completion pulse
module seq_gen_1010 #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter int               CNT_W   = 8,
    parameter int               GAP_W   = 4
) (
    input  logic          clk,
    input  logic          rst,
    seq_gen_1010_if.slave bus
);
    localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] REP_ONE = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] reps_q, reps_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic             x_out_q, x_vld_q, sof_q, busy_q, done_q;
    logic             x_out_d, x_vld_d, sof_d, busy_d, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
            reps_q  <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            x_out_q <= 1'b0;
            x_vld_q <= 1'b0;
            sof_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            reps_q  <= reps_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            x_out_q <= x_out_d;
            x_vld_q <= x_vld_d;
            sof_q   <= sof_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        reps_d  = reps_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = SEND;
                    pat_d   = bus.use_def ? PATTERN : bus.pat_in;
                    reps_d  = (bus.rep_cnt == '0) ? REP_ONE : bus.rep_cnt;
                    gap_d   = bus.gap_cnt;
                    idx_d   = IDX_MAX;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    // reps_q is at least 1 here, so this never wraps
                    reps_d = reps_q - REP_ONE;
                    if (reps_q == REP_ONE) begin
                        state_d = DONE;
                    end else if (gap_q != '0) begin
                        state_d = GAP;
                        gcnt_d  = gap_q;
                    end else begin
                        idx_d = IDX_MAX;
                    end
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            GAP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (gcnt_q <= GAP_ONE) begin
                    state_d = SEND;
                    idx_d   = IDX_MAX;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q - GAP_ONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and registered
        x_vld_d = (state_d == SEND);
        sof_d   = x_vld_d && (idx_d == IDX_MAX);
        x_out_d = x_vld_d && pat_d[idx_d];
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    assign bus.x_out = x_out_q;
    assign bus.x_vld = x_vld_q;
    assign bus.sof   = sof_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_seq_gen_1010.sv
// Directed bench for seq_gen_1010; observed vector per cycle is {busy,done,x_vld,sof,x_out}.
module tb_seq_gen_1010;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    seq_gen_1010_if #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) bus ();

    seq_gen_1010 #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(8), .GAP_W(4)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] obs();
        return {bus.busy, bus.done, bus.x_vld, bus.sof, bus.x_out};
    endfunction

    task automatic cyc(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, obs()}, {27'd0, exp});
        @(negedge clk);
    endtask

    // Returns at the negedge of cycle 1 (first bit on the wire)
    task automatic launch(input logic ud, input logic [3:0] p, input logic [7:0] rc, input logic [3:0] gc);
        bus.use_def = ud;
        bus.pat_in  = p;
        bus.rep_cnt = rc;
        bus.gap_cnt = gc;
        bus.start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    initial begin
        logic [3:0] sh;
        int         hits;
        int         nv;
        int         ns;
        bit         seen;

        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.use_def = 1'b1;
        bus.pat_in  = 4'h0;
        bus.rep_cnt = 8'd1;
        bus.gap_cnt = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_outs", {27'd0, obs()}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs", {27'd0, obs()}, 32'd0);

        // Asynchronous reset in the middle of a burst
        launch(1'b1, 4'h0, 8'd3, 4'd0);
        cyc("rst_pre_c1", 5'b10111);
        #2 rst_n = 1'b0;
        #1 check("rst_async", {27'd0, obs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_stay_idle", {27'd0, obs()}, 32'd0);

        // Default single burst
        launch(1'b1, 4'h0, 8'd1, 4'd0);
        cyc("one_c1", 5'b10111);
        cyc("one_c2", 5'b10100);
        cyc("one_c3", 5'b10101);
        cyc("one_c4", 5'b10100);
        cyc("one_c5_done", 5'b11000);
        cyc("one_c6_idle", 5'b00000);

        // Three back-to-back repetitions, with a 1010 overlap detector
        sh = 4'h0;
        hits = 0;
        launch(1'b1, 4'h0, 8'd3, 4'd0);
        for (int c = 0; c < 12; c++) begin
            sh = {sh[2:0], bus.x_out};
            if (bus.x_vld && sh == 4'b1010) hits++;
            cyc("b2b_bit", {1'b1, 1'b0, 1'b1, (c % 4) == 0, (c % 2) == 0});
        end
        cyc("b2b_done", 5'b11000);
        cyc("b2b_idle", 5'b00000);
        check("b2b_hits", hits, 5);

        // User pattern 1100 with a 3-cycle gap
        launch(1'b0, 4'b1100, 8'd2, 4'd3);
        cyc("gap_c1", 5'b10111);
        cyc("gap_c2", 5'b10101);
        cyc("gap_c3", 5'b10100);
        cyc("gap_c4", 5'b10100);
        for (int c = 5; c <= 7; c++) cyc("gap_idle", 5'b10000);
        cyc("gap_c8", 5'b10111);
        cyc("gap_c9", 5'b10101);
        cyc("gap_c10", 5'b10100);
        cyc("gap_c11", 5'b10100);
        cyc("gap_c12_done", 5'b11000);
        cyc("gap_c13_idle", 5'b00000);

        // rep_cnt=0 behaves as one repetition
        launch(1'b1, 4'h0, 8'd0, 4'd2);
        cyc("rep0_c1", 5'b10111);
        cyc("rep0_c2", 5'b10100);
        cyc("rep0_c3", 5'b10101);
        cyc("rep0_c4", 5'b10100);
        cyc("rep0_done", 5'b11000);
        cyc("rep0_idle", 5'b00000);

        // Abort during the second repetition
        launch(1'b1, 4'h0, 8'd3, 4'd0);
        for (int c = 0; c < 5; c++) cyc("abt_bit", {1'b1, 1'b0, 1'b1, (c % 4) == 0, (c % 2) == 0});
        check("abt_c6", {27'd0, obs()}, {27'd0, 5'b10100});
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        for (int c = 0; c < 6; c++) cyc("abt_quiet", 5'b00000);

        // start while busy is ignored
        launch(1'b1, 4'h0, 8'd2, 4'd0);
        cyc("sib_c1", 5'b10111);
        bus.use_def = 1'b0;
        bus.pat_in  = 4'b0000;
        bus.rep_cnt = 8'd5;
        bus.gap_cnt = 4'd7;
        bus.start   = 1'b1;
        cyc("sib_c2", 5'b10100);
        bus.start   = 1'b0;
        for (int c = 2; c < 8; c++) cyc("sib_bit", {1'b1, 1'b0, 1'b1, (c % 4) == 0, (c % 2) == 0});
        cyc("sib_done", 5'b11000);
        cyc("sib_idle", 5'b00000);
        cyc("sib_idle2", 5'b00000);

        // start and abort together in IDLE
        bus.use_def = 1'b1;
        bus.start   = 1'b1;
        bus.abort   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        for (int c = 0; c < 4; c++) cyc("sa_none", 5'b00000);

        // Maximum repetition count: 255 reps, no wrap
        nv = 0;
        ns = 0;
        seen = 1'b0;
        launch(1'b1, 4'h0, 8'd255, 4'd0);
        for (int c = 0; c < 1100 && !seen; c++) begin
            if (bus.x_vld) nv++;
            if (bus.sof) ns++;
            if (bus.done) seen = 1'b1;
            else @(negedge clk);
        end
        check("max_done_seen", {31'd0, seen}, 32'd1);
        check("max_valid_bits", nv, 1020);
        check("max_sof", ns, 255);
        @(negedge clk);
        check("max_idle", {27'd0, obs()}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
